// File: rtl/ewb_drain_pkg.sv
// Shared types and constants for the eviction write buffer drain engine.
package ewb_drain_pkg;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_WRITE = 2'd1,
    DRAIN_DONE  = 2'd2
  } drain_state_e;

  localparam int LINE_OFFSET_BITS = 5;
  localparam int BEATS            = 4;
  localparam int BEAT_IDX_W       = $clog2(BEATS);

endpackage

// File: rtl/ewb_drain.sv
// Pulls one dirty line per transaction off the eviction buffer and writes it as a 4-beat burst.
// Yumi is combinational in IDLE; first write beat 1 cycle later; pending reads hold off burst start only.
module ewb_drain
  import ewb_drain_pkg::*;
#(
  parameter int WIDTH  = 256,
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ewb_valid_i,
  input  logic [ADDR_W-1:0] ewb_addr_i,
  input  logic [WIDTH-1:0]  ewb_data_i,
  output logic              ewb_yumi_o,
  input  logic              rd_req_i,
  output logic              busy_o,
  input  logic [ADDR_W-1:0] snoop_addr_i,
  output logic              snoop_hit_o,
  output logic [WIDTH-1:0]  snoop_data_o,
  output logic              pmem_write_o,
  output logic [ADDR_W-1:0] pmem_address_o,
  output logic [BEAT_W-1:0] pmem_wdata_o,
  input  logic              pmem_resp_i
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFFSET_BITS) - 1);
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  drain_state_e          state_q, state_d;
  logic [BEAT_IDX_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]      line_q, line_d;
  logic                  take;
  logic                  beat_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DRAIN_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    line_d  = line_q;
    unique case (state_q)
      DRAIN_IDLE: begin
        if (take) begin
          state_d = DRAIN_WRITE;
          addr_d  = ewb_addr_i & LINE_MASK;
          line_d  = ewb_data_i;
          beat_d  = '0;
        end
      end
      DRAIN_WRITE: begin
        if (pmem_resp_i) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = DRAIN_DONE;
          end
        end
      end
      DRAIN_DONE: begin
        state_d = DRAIN_IDLE;
      end
      default: begin
        state_d = DRAIN_IDLE;
      end
    endcase
  end

  // Outputs; take is gated by rst so no line is consumed while the block is held in reset
  always_comb begin
    take           = (state_q == DRAIN_IDLE) & ewb_valid_i & ~rd_req_i & ~rst;
    beat_done      = (state_q == DRAIN_WRITE) & pmem_resp_i;
    ewb_yumi_o     = take;
    busy_o         = (state_q != DRAIN_IDLE);
    pmem_write_o   = (state_q == DRAIN_WRITE);
    pmem_address_o = addr_q;
    pmem_wdata_o   = line_q[beat_q*BEAT_W +: BEAT_W];
    snoop_data_o   = line_q;
    // addr_q already has its offset bits cleared, so masking the snoop makes this a line compare
    snoop_hit_o    = (state_q == DRAIN_WRITE) & ((snoop_addr_i & LINE_MASK) == addr_q);
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && beat_done && beat_q == LAST_BEAT) begin
      assert (state_d == DRAIN_DONE);
    end
  end
`endif

endmodule

// File: tb/tb_ewb_drain.sv
// Randomized scoreboard bench for ewb_drain against a transaction-level model.
module tb_ewb_drain;

  localparam int WIDTH  = 256;
  localparam int ADDR_W = 32;
  localparam int BEAT_W = 64;

  logic              clk;
  logic              rst;
  logic              ewb_valid_i;
  logic [ADDR_W-1:0] ewb_addr_i;
  logic [WIDTH-1:0]  ewb_data_i;
  logic              ewb_yumi_o;
  logic              rd_req_i;
  logic              busy_o;
  logic [ADDR_W-1:0] snoop_addr_i;
  logic              snoop_hit_o;
  logic [WIDTH-1:0]  snoop_data_o;
  logic              pmem_write_o;
  logic [ADDR_W-1:0] pmem_address_o;
  logic [BEAT_W-1:0] pmem_wdata_o;
  logic              pmem_resp_i;

  ewb_drain #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ewb_valid_i    (ewb_valid_i),
    .ewb_addr_i     (ewb_addr_i),
    .ewb_data_i     (ewb_data_i),
    .ewb_yumi_o     (ewb_yumi_o),
    .rd_req_i       (rd_req_i),
    .busy_o         (busy_o),
    .snoop_addr_i   (snoop_addr_i),
    .snoop_hit_o    (snoop_hit_o),
    .snoop_data_o   (snoop_data_o),
    .pmem_write_o   (pmem_write_o),
    .pmem_address_o (pmem_address_o),
    .pmem_wdata_o   (pmem_wdata_o),
    .pmem_resp_i    (pmem_resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } line_t;

  line_t             buf_q[$];
  logic [BEAT_W-1:0] exp_beats[$];

  // Transaction model: remaining beats of the burst in flight plus a one-cycle gap after it
  int                beats_left = 0;
  bit                gap = 1'b0;
  logic [ADDR_W-1:0] cur_addr = '0;
  logic [WIDTH-1:0]  cur_line = '0;

  int n_checks = 0;
  int n_fail   = 0;

  bit drive_valid = 1'b0;
  int resp_mode   = 0;
  int snoop_mode  = 0;
  int wait_cnt    = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor and scoreboard
  logic  exp_yumi, exp_write, exp_busy, exp_hit;
  line_t popped;
  always @(negedge clk) begin
    exp_write = !rst && beats_left > 0;
    exp_busy  = !rst && (beats_left > 0 || gap);
    exp_yumi  = !rst && beats_left == 0 && !gap && ewb_valid_i && !rd_req_i;
    exp_hit   = exp_write && (snoop_addr_i[ADDR_W-1:5] == cur_addr[ADDR_W-1:5]);
    check("yumi", WIDTH'(ewb_yumi_o), WIDTH'(exp_yumi));
    check("pmem_write", WIDTH'(pmem_write_o), WIDTH'(exp_write));
    check("busy", WIDTH'(busy_o), WIDTH'(exp_busy));
    check("snoop_hit", WIDTH'(snoop_hit_o), WIDTH'(exp_hit));
    if (exp_write) begin
      check("pmem_address", WIDTH'(pmem_address_o), WIDTH'(cur_addr));
      check("snoop_data", snoop_data_o, cur_line);
      if (exp_beats.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wdata_underflow: got %h expected no write", pmem_wdata_o);
      end else begin
        check("pmem_wdata", WIDTH'(pmem_wdata_o), WIDTH'(exp_beats[0]));
      end
    end
    if (rst) begin
      beats_left = 0;
      gap        = 1'b0;
      cur_addr   = '0;
      cur_line   = '0;
      exp_beats.delete();
    end else if (beats_left > 0) begin
      if (pmem_resp_i) begin
        if (exp_beats.size() > 0) void'(exp_beats.pop_front());
        beats_left--;
        if (beats_left == 0) gap = 1'b1;
      end
    end else if (gap) begin
      gap = 1'b0;
    end else if (exp_yumi && buf_q.size() > 0) begin
      popped   = buf_q.pop_front();
      cur_addr = popped.addr & ~32'h1f;
      cur_line = popped.data;
      for (int k = 0; k < 4; k++) exp_beats.push_back(popped.data[k*BEAT_W +: BEAT_W]);
      beats_left = 4;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    ewb_valid_i = drive_valid && buf_q.size() > 0;
    ewb_addr_i  = (buf_q.size() > 0) ? buf_q[0].addr : '0;
    ewb_data_i  = (buf_q.size() > 0) ? buf_q[0].data : '0;
    case (resp_mode)
      0: pmem_resp_i = 1'b1;
      1: begin
        if (!pmem_write_o) begin
          wait_cnt    = 0;
          pmem_resp_i = 1'b0;
        end else begin
          pmem_resp_i = (wait_cnt == 2);
          wait_cnt    = (wait_cnt == 2) ? 0 : wait_cnt + 1;
        end
      end
      default: pmem_resp_i = $urandom_range(0, 1) == 1;
    endcase
    if (snoop_mode == 0) begin
      case ($urandom_range(0, 3))
        0: snoop_addr_i = 32'h0000_123C;
        1: snoop_addr_i = 32'h0000_1240;
        2: snoop_addr_i = 32'h0000_1220;
        default: snoop_addr_i = 32'h0000_1200;
      endcase
    end else begin
      snoop_addr_i = ($urandom_range(0, 1) == 1) ? (cur_addr | 32'($urandom_range(0, 31))) : $urandom;
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_line();
    logic [WIDTH-1:0] d;
    for (int k = 0; k < WIDTH/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic push_line(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    line_t l;
    l.addr = a;
    l.data = d;
    buf_q.push_back(l);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (buf_q.size() == 0 && beats_left == 0 && !gap) return;
      cycle();
    end
    n_checks++;
    n_fail++;
    $display("FAIL drain_timeout: got %0d lines pending expected 0", buf_q.size());
  endtask

  task automatic wait_beats(input int target, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (beats_left == target) return;
      cycle();
    end
    n_checks++;
    n_fail++;
    $display("FAIL beat_timeout: got %0d beats left expected %0d", beats_left, target);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] pat;
    rst          = 1'b1;
    ewb_valid_i  = 1'b0;
    ewb_addr_i   = '0;
    ewb_data_i   = '0;
    rd_req_i     = 1'b0;
    snoop_addr_i = '0;
    pmem_resp_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ewb_valid_i = 1'b1;
    ewb_addr_i  = 32'h0000_1234;
    #1;
    check("rst_yumi", WIDTH'(ewb_yumi_o), '0);
    check("rst_write", WIDTH'(pmem_write_o), '0);
    check("rst_busy", WIDTH'(busy_o), '0);
    check("rst_snoop_data", snoop_data_o, '0);
    ewb_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_valid = 1'b1;

    for (int k = 0; k < 4; k++) pat[k*64 +: 64] = 64'hAAAA_0000_0000_0000 | 64'(k);
    push_line(32'h0000_1234, pat);
    resp_mode = 0;
    wait_drain(40);
    repeat (3) cycle();

    push_line(32'h0000_1234, rand_line());
    resp_mode = 1;
    wait_drain(60);
    repeat (2) cycle();

    resp_mode = 0;
    rd_req_i  = 1'b1;
    push_line(32'h0000_1238, rand_line());
    repeat (5) cycle();
    rd_req_i = 1'b0;
    wait_drain(40);

    push_line(32'h0000_1220, rand_line());
    wait_beats(4, 20);
    rd_req_i = 1'b1;
    resp_mode = 2;
    wait_drain(80);
    rd_req_i  = 1'b0;
    resp_mode = 0;
    cycle();

    push_line(32'h0000_1234, rand_line());
    push_line(32'h0000_1240, rand_line());
    wait_drain(60);
    cycle();

    push_line(32'h0000_123F, rand_line());
    wait_beats(2, 20);
    rst = 1'b1;
    #1;
    check("rst_async_write", WIDTH'(pmem_write_o), '0);
    check("rst_async_busy", WIDTH'(busy_o), '0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    resp_mode  = 2;
    snoop_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      cycle();
      if (buf_q.size() < 3 && $urandom_range(0, 3) == 0)
        push_line($urandom, rand_line());
      rd_req_i = ($urandom_range(0, 4) == 0);
    end
    rd_req_i = 1'b0;
    wait_drain(400);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
